vector_regfile_stream: RTL and testbench

Parametrised vector register file: NUM_REG registers of NUM_ELE elements, each DATA_WIDTH bits. Provides NUM_RD asynchronous element read ports and a single-element write port. Adds a streaming whole-register write (LANES elements per beat, valid/ready handshake) and a multi-cycle register clear, sequenced by an FSM. Sits in the vector unit between the load path, which streams whole vectors in, and the execute lanes, which read elements.

---
 rtl/vrf_pkg.sv | 21 ++
 rtl/vrf_stream_ctrl.sv | 116 +++++++++++
 rtl/vector_regfile_stream.sv | 128 ++++++++++++
 tb/tb_vector_regfile_stream.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared types and derived-width helpers for the streaming vector register file.
package vrf_pkg;

  // Sequencer states: idle, accepting stream beats, or zeroing a register.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CLEAR  = 2'd2
  } vrf_state_e;

  // Width of the beat counter; never below one bit, even for a single-beat register.
  function automatic int vrf_beat_aw(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Number of low element-index bits that select a lane within a beat.
  function automatic int vrf_lane_aw(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 0;
  endfunction

endpackage

// File: rtl/vrf_stream_ctrl.sv
// Sequencer for whole-register stream writes and multi-cycle clears.
// Drives a lane write strobe, target register, base element and zero-select
// towards the array; handshake and status outputs are registered.
module vrf_stream_ctrl
  import vrf_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int ELE_AW = 5,
  parameter int LANES  = 4,
  parameter int BEATS  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [REG_AW-1:0] reg_i,
  input  logic              valid_i,
  output logic              vw_ready_o,
  output logic              w_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              lane_we_o,
  output logic [REG_AW-1:0] wr_reg_o,
  output logic [ELE_AW-1:0] wr_base_o,
  output logic              zero_sel_o
);

  localparam int BEAT_AW = vrf_beat_aw(BEATS);
  localparam int LANE_AW = vrf_lane_aw(LANES);

  vrf_state_e         state_q;
  logic [BEAT_AW-1:0] beat_q;
  logic [REG_AW-1:0]  reg_q;
  logic               busy_q;
  logic               w_ready_q;
  logic               vw_ready_q;
  logic               done_q;
  logic               last_beat_s;

  assign last_beat_s = (beat_q == BEAT_AW'(BEATS - 1));

  // FSM: state, beat counter, captured register and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      reg_q      <= '0;
      busy_q     <= 1'b0;
      w_ready_q  <= 1'b1;
      vw_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            reg_q     <= reg_i;
            beat_q    <= '0;
            busy_q    <= 1'b1;
            w_ready_q <= 1'b0;
            if (clear_i) begin
              state_q    <= ST_CLEAR;
              vw_ready_q <= 1'b0;
            end else begin
              state_q    <= ST_STREAM;
              vw_ready_q <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (valid_i && vw_ready_q) begin
            if (last_beat_s) begin
              state_q    <= ST_IDLE;
              beat_q     <= '0;
              busy_q     <= 1'b0;
              w_ready_q  <= 1'b1;
              vw_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (last_beat_s) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            busy_q     <= 1'b0;
            w_ready_q  <= 1'b1;
            vw_ready_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          beat_q     <= '0;
          busy_q     <= 1'b0;
          w_ready_q  <= 1'b1;
          vw_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign vw_ready_o = vw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign lane_we_o  = (vw_ready_q && valid_i) || (state_q == ST_CLEAR);
  assign wr_reg_o   = reg_q;
  assign wr_base_o  = ELE_AW'(beat_q) << LANE_AW;
  assign zero_sel_o = (state_q == ST_CLEAR);

endmodule

// File: rtl/vector_regfile_stream.sv
// Vector register file: NUM_REG x NUM_ELE elements, NUM_RD combinational element
// read ports, a single-element write port, and LANES-wide stream/clear writes
// sequenced by vrf_stream_ctrl. Optional same-cycle write-to-read forwarding.
module vector_regfile_stream
  import vrf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 16,
  parameter int NUM_ELE    = 32,
  parameter int NUM_RD     = 2,
  parameter int LANES      = 4,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_RD*$clog2(NUM_REG)-1:0] rd_reg,
  input  logic [NUM_RD*$clog2(NUM_ELE)-1:0] rd_ele,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
  input  logic                             we,
  input  logic [$clog2(NUM_REG)-1:0]       w_reg,
  input  logic [$clog2(NUM_ELE)-1:0]       w_ele,
  input  logic [DATA_WIDTH-1:0]            w_data,
  output logic                             w_ready,
  input  logic                             vw_start,
  input  logic                             vw_clear,
  input  logic [$clog2(NUM_REG)-1:0]       vw_reg,
  input  logic                             vw_valid,
  output logic                             vw_ready,
  input  logic [LANES*DATA_WIDTH-1:0]      vw_data,
  output logic                             busy,
  output logic                             vw_done
);

  localparam int REG_AW = $clog2(NUM_REG);
  localparam int ELE_AW = $clog2(NUM_ELE);
  localparam int BEATS  = NUM_ELE / LANES;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REG][NUM_ELE];

  logic                  lane_we_s;
  logic [REG_AW-1:0]     lane_reg_s;
  logic [ELE_AW-1:0]     lane_base_s;
  logic                  zero_sel_s;
  logic                  elem_we_s;
  logic [DATA_WIDTH-1:0] lane_wdata_s [LANES];
  logic [REG_AW-1:0]     rd_reg_s [NUM_RD];
  logic [ELE_AW-1:0]     rd_ele_s [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_word_s [NUM_RD];

  vrf_stream_ctrl #(
    .REG_AW (REG_AW),
    .ELE_AW (ELE_AW),
    .LANES  (LANES),
    .BEATS  (BEATS)
  ) u_ctrl (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (vw_start),
    .clear_i    (vw_clear),
    .reg_i      (vw_reg),
    .valid_i    (vw_valid),
    .vw_ready_o (vw_ready),
    .w_ready_o  (w_ready),
    .busy_o     (busy),
    .done_o     (vw_done),
    .lane_we_o  (lane_we_s),
    .wr_reg_o   (lane_reg_s),
    .wr_base_o  (lane_base_s),
    .zero_sel_o (zero_sel_s)
  );

  // Element writes are only honoured while the sequencer is idle.
  assign elem_we_s = we && w_ready;

  // Per-lane write data: stream lanes, or zeros while clearing.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_wdata_s[i] = zero_sel_s ? '0 : vw_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Array storage: reset zeroes everything, otherwise apply element and lane writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REG; r++) begin
        for (int e = 0; e < NUM_ELE; e++) begin
          mem_q[r][e] <= '0;
        end
      end
    end else begin
      if (elem_we_s) begin
        mem_q[w_reg][w_ele] <= w_data;
      end
      if (lane_we_s) begin
        for (int i = 0; i < LANES; i++) begin
          mem_q[lane_reg_s][lane_base_s | ELE_AW'(i)] <= lane_wdata_s[i];
        end
      end
    end
  end

  // Unpack per-port read addresses and pack read data.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    assign rd_reg_s[p] = rd_reg[p*REG_AW +: REG_AW];
    assign rd_ele_s[p] = rd_ele[p*ELE_AW +: ELE_AW];
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_word_s[p];
  end

  // Read ports: array contents, optionally overridden by a write to the same element this cycle.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word_s[p] = mem_q[rd_reg_s[p]][rd_ele_s[p]];
      if ((BYPASS != 0) && !reset) begin
        if (elem_we_s && (w_reg == rd_reg_s[p]) && (w_ele == rd_ele_s[p])) begin
          rd_word_s[p] = w_data;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_we_s && (lane_reg_s == rd_reg_s[p]) &&
                ((lane_base_s | ELE_AW'(i)) == rd_ele_s[p])) begin
              rd_word_s[p] = lane_wdata_s[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_regfile_stream.sv
// Self-checking bench for vector_regfile_stream: reference array model plus a
// queue of expected read values pushed when stimulus is driven.
module tb_vector_regfile_stream;

  localparam int DW    = 32;
  localparam int NR    = 16;
  localparam int NE    = 32;
  localparam int NRD   = 2;
  localparam int LN    = 4;
  localparam int BYP   = 1;
  localparam int RAW   = 4;
  localparam int EAW   = 5;
  localparam int BEATS = NE / LN;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NRD*RAW-1:0] rd_reg = '0;
  logic [NRD*EAW-1:0] rd_ele = '0;
  logic [NRD*DW-1:0]  rd_data;
  logic              we = 1'b0;
  logic [RAW-1:0]    w_reg = '0;
  logic [EAW-1:0]    w_ele = '0;
  logic [DW-1:0]     w_data = '0;
  logic              w_ready;
  logic              vw_start = 1'b0;
  logic              vw_clear = 1'b0;
  logic [RAW-1:0]    vw_reg = '0;
  logic              vw_valid = 1'b0;
  logic              vw_ready;
  logic [LN*DW-1:0]  vw_data = '0;
  logic              busy;
  logic              vw_done;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ref_mem [NR][NE];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] got;

  vector_regfile_stream #(
    .DATA_WIDTH (DW), .NUM_REG (NR), .NUM_ELE (NE),
    .NUM_RD (NRD), .LANES (LN), .BYPASS (BYP)
  ) dut (
    .clk (clk), .reset (reset), .rd_reg (rd_reg), .rd_ele (rd_ele), .rd_data (rd_data),
    .we (we), .w_reg (w_reg), .w_ele (w_ele), .w_data (w_data), .w_ready (w_ready),
    .vw_start (vw_start), .vw_clear (vw_clear), .vw_reg (vw_reg), .vw_valid (vw_valid),
    .vw_ready (vw_ready), .vw_data (vw_data), .busy (busy), .vw_done (vw_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int r, input int e);
    rd_reg[p*RAW +: RAW] = RAW'(r);
    rd_ele[p*EAW +: EAW] = EAW'(e);
  endtask

  // Drives one accepted stream beat and records it in the model.
  task automatic drive_beat(input int r, input int b, input logic [DW-1:0] base);
    vw_valid = 1'b1;
    for (int i = 0; i < LN; i++) vw_data[i*DW +: DW] = base + DW'(b*LN + i);
    cyc();
    vw_valid = 1'b0;
    for (int i = 0; i < LN; i++) ref_mem[r][b*LN + i] = base + DW'(b*LN + i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int r = 0; r < NR; r++) for (int e = 0; e < NE; e++) ref_mem[r][e] = '0;
    set_rd(0, 5, 7);
    set_rd(1, 5, 7);
    exp_q.push_back(ref_mem[5][7]);
    exp_q.push_back(ref_mem[5][7]);
    #1;
    for (int p = 0; p < NRD; p++) begin
      exp_v = exp_q.pop_front();
      got = rd_data[p*DW +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_read port%0d got=%h exp=%h", p, got, exp_v); end
    end
    checks++;
    if (busy !== 1'b0 || w_ready !== 1'b1 || vw_ready !== 1'b0 || vw_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b w_ready=%b vw_ready=%b done=%b exp=0100", busy, w_ready, vw_ready, vw_done);
    end
  endtask

  task automatic test_elem_write();
    cyc();
    we = 1'b1; w_reg = 4'd3; w_ele = 5'd9; w_data = 32'hDEADBEEF;
    set_rd(0, 3, 9);
    set_rd(1, 3, 8);
    exp_q.push_back((BYP != 0) ? 32'hDEADBEEF : ref_mem[3][9]);
    exp_q.push_back(ref_mem[3][8]);
    #1;
    for (int p = 0; p < NRD; p++) begin
      exp_v = exp_q.pop_front();
      got = rd_data[p*DW +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL elem_same_cycle port%0d got=%h exp=%h", p, got, exp_v); end
    end
    cyc();
    we = 1'b0;
    ref_mem[3][9] = 32'hDEADBEEF;
    set_rd(1, 3, 9);
    exp_q.push_back(ref_mem[3][9]);
    exp_q.push_back(ref_mem[3][9]);
    #1;
    for (int p = 0; p < NRD; p++) begin
      exp_v = exp_q.pop_front();
      got = rd_data[p*DW +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL elem_next_cycle port%0d got=%h exp=%h", p, got, exp_v); end
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] v;
    cyc();
    vw_start = 1'b1; vw_clear = 1'b0; vw_reg = 4'd2;
    #1;
    checks++;
    if (vw_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stream_idle vw_ready=%b busy=%b exp=0 0", vw_ready, busy);
    end
    cyc();
    vw_start = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == 4) begin
        for (int s = 0; s < 2; s++) begin
          vw_valid = 1'b0;
          #1;
          checks++;
          if (vw_ready !== 1'b1 || busy !== 1'b1 || vw_done !== 1'b0) begin
            failures++; $display("FAIL stream_stall vw_ready=%b busy=%b done=%b exp=1 1 0", vw_ready, busy, vw_done);
          end
          cyc();
        end
      end
      vw_valid = 1'b1;
      for (int i = 0; i < LN; i++) vw_data[i*DW +: DW] = 32'h100 + DW'(b*LN + i);
      if (b == 1) begin
        we = 1'b1; w_reg = 4'd5; w_ele = 5'd1; w_data = 32'hBAD0BAD0;
      end
      v = 32'h100 + DW'(b*LN + 2);
      set_rd(1, 2, b*LN + 2);
      exp_q.push_back((BYP != 0) ? v : ref_mem[2][b*LN + 2]);
      #1;
      exp_v = exp_q.pop_front();
      got = rd_data[DW +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL stream_bypass beat%0d got=%h exp=%h", b, got, exp_v); end
      checks++;
      if (vw_ready !== 1'b1 || w_ready !== 1'b0 || vw_done !== 1'b0) begin
        failures++; $display("FAIL stream_beat%0d vw_ready=%b w_ready=%b done=%b exp=1 0 0", b, vw_ready, w_ready, vw_done);
      end
      cyc();
      we = 1'b0;
      vw_valid = 1'b0;
      for (int i = 0; i < LN; i++) ref_mem[2][b*LN + i] = 32'h100 + DW'(b*LN + i);
    end
    #1;
    checks++;
    if (vw_done !== 1'b1 || busy !== 1'b0 || w_ready !== 1'b1) begin
      failures++; $display("FAIL stream_done done=%b busy=%b w_ready=%b exp=1 0 1", vw_done, busy, w_ready);
    end
    cyc();
    checks++;
    if (vw_done !== 1'b0) begin failures++; $display("FAIL stream_done_pulse done=%b exp=0", vw_done); end
    set_rd(0, 2, 17);
    set_rd(1, 5, 1);
    exp_q.push_back(32'h111);
    exp_q.push_back(ref_mem[5][1]);
    #1;
    for (int p = 0; p < NRD; p++) begin
      exp_v = exp_q.pop_front();
      got = rd_data[p*DW +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL stream_readback port%0d got=%h exp=%h", p, got, exp_v); end
    end
    for (int e = 0; e < NE; e++) begin
      cyc();
      set_rd(0, 2, e);
      exp_q.push_back(ref_mem[2][e]);
      #1;
      exp_v = exp_q.pop_front();
      got = rd_data[0 +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL stream_reg2 ele%0d got=%h exp=%h", e, got, exp_v); end
    end
  endtask

  task automatic test_clear();
    for (int e = 0; e < NE; e++) begin
      cyc();
      we = 1'b1; w_reg = 4'd4; w_ele = EAW'(e); w_data = 32'h4000 + DW'(e);
      ref_mem[4][e] = 32'h4000 + DW'(e);
    end
    cyc();
    we = 1'b0;
    vw_start = 1'b1; vw_clear = 1'b1; vw_reg = 4'd4;
    cyc();
    vw_start = 1'b0; vw_clear = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      set_rd(0, 4, k*LN + 1);
      exp_q.push_back((BYP != 0) ? '0 : ref_mem[4][k*LN + 1]);
      #1;
      checks++;
      if (busy !== 1'b1 || vw_ready !== 1'b0 || vw_done !== 1'b0) begin
        failures++; $display("FAIL clear_cycle%0d busy=%b vw_ready=%b done=%b exp=1 0 0", k, busy, vw_ready, vw_done);
      end
      exp_v = exp_q.pop_front();
      got = rd_data[0 +: DW];
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL clear_bypass cycle%0d got=%h exp=%h", k, got, exp_v); end
      cyc();
    end
    for (int e = 0; e < NE; e++) ref_mem[4][e] = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || vw_done !== 1'b1) begin
      failures++; $display("FAIL clear_done busy=%b done=%b exp=0 1", busy, vw_done);
    end
    for (int e = 0; e < NE; e++) begin
      cyc();
      set_rd(0, 4, e);
      set_rd(1, 3, e);
      exp_q.push_back(ref_mem[4][e]);
      exp_q.push_back(ref_mem[3][e]);
      #1;
      for (int p = 0; p < NRD; p++) begin
        exp_v = exp_q.pop_front();
        got = rd_data[p*DW +: DW];
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL clear_readback port%0d ele%0d got=%h exp=%h", p, e, got, exp_v); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    vw_start = 1'b1; vw_clear = 1'b0; vw_reg = 4'd6;
    cyc();
    vw_start = 1'b0;
    for (int b = 0; b < 3; b++) drive_beat(6, b, 32'h600);
    reset = 1'b1;
    vw_valid = 1'b1;
    for (int i = 0; i < LN; i++) vw_data[i*DW +: DW] = 32'h60C + DW'(i);
    cyc();
    reset = 1'b0;
    vw_valid = 1'b0;
    for (int r = 0; r < NR; r++) for (int e = 0; e < NE; e++) ref_mem[r][e] = '0;
    #1;
    checks++;
    if (vw_done !== 1'b0 || busy !== 1'b0 || w_ready !== 1'b1 || vw_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_status done=%b busy=%b w_ready=%b vw_ready=%b exp=0 0 1 0", vw_done, busy, w_ready, vw_ready);
    end
    cyc();
    checks++;
    if (vw_done !== 1'b0) begin failures++; $display("FAIL midreset_no_done done=%b exp=0", vw_done); end
    for (int e = 0; e < 16; e++) begin
      cyc();
      set_rd(0, 6, e);
      set_rd(1, 3, 9);
      exp_q.push_back(ref_mem[6][e]);
      exp_q.push_back(ref_mem[3][9]);
      #1;
      for (int p = 0; p < NRD; p++) begin
        exp_v = exp_q.pop_front();
        got = rd_data[p*DW +: DW];
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL midreset_zero port%0d ele%0d got=%h exp=%h", p, e, got, exp_v); end
      end
    end
    cyc();
    vw_start = 1'b1; vw_reg = 4'd7;
    cyc();
    vw_start = 1'b0;
    for (int b = 0; b < BEATS; b++) drive_beat(7, b, 32'h700);
    #1;
    checks++;
    if (vw_done !== 1'b1) begin failures++; $display("FAIL midreset_restream_done done=%b exp=1", vw_done); end
    for (int e = 0; e < NE; e++) begin
      cyc();
      set_rd(0, 7, e);
      set_rd(1, 2, e);
      exp_q.push_back(ref_mem[7][e]);
      exp_q.push_back(ref_mem[2][e]);
      #1;
      for (int p = 0; p < NRD; p++) begin
        exp_v = exp_q.pop_front();
        got = rd_data[p*DW +: DW];
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL midreset_restream port%0d ele%0d got=%h exp=%h", p, e, got, exp_v); end
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    vw_start = 1'b1; vw_clear = 1'b0; vw_reg = 4'd8;
    cyc();
    vw_start = 1'b0;
    for (int b = 0; b < BEATS; b++) drive_beat(8, b, 32'h800);
    vw_start = 1'b1; vw_reg = 4'd9;
    #1;
    checks++;
    if (vw_done !== 1'b1) begin failures++; $display("FAIL b2b_first_done done=%b exp=1", vw_done); end
    cyc();
    vw_start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || vw_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_second_start busy=%b vw_ready=%b exp=1 1", busy, vw_ready);
    end
    for (int b = 0; b < BEATS; b++) drive_beat(9, b, 32'h900);
    vw_start = 1'b1; vw_clear = 1'b1; vw_reg = 4'd8;
    #1;
    checks++;
    if (vw_done !== 1'b1) begin failures++; $display("FAIL b2b_second_done done=%b exp=1", vw_done); end
    cyc();
    vw_start = 1'b0; vw_clear = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || vw_done !== 1'b0) begin
        failures++; $display("FAIL b2b_clear_cycle%0d busy=%b done=%b exp=1 0", k, busy, vw_done);
      end
      cyc();
    end
    for (int e = 0; e < NE; e++) ref_mem[8][e] = '0;
    #1;
    checks++;
    if (vw_done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_clear_done done=%b busy=%b exp=1 0", vw_done, busy);
    end
    for (int e = 0; e < NE; e++) begin
      cyc();
      set_rd(0, 8, e);
      set_rd(1, 9, e);
      exp_q.push_back(ref_mem[8][e]);
      exp_q.push_back(ref_mem[9][e]);
      #1;
      for (int p = 0; p < NRD; p++) begin
        exp_v = exp_q.pop_front();
        got = rd_data[p*DW +: DW];
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL b2b_readback port%0d ele%0d got=%h exp=%h", p, e, got, exp_v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_elem_write();
    test_stream();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
